memory_access_cycle: RTL and testbench

//  MEM stage of the RV32I pipeline; consumes the EX->MEM outputs of the execute stage (RegWriteM, MemWriteM,

---
 rtl/memory_access_cycle_pkg.sv | 26 ++
 rtl/memory_access_cycle_mem_wb_reg.sv | 78 +++++++
 rtl/memory_access_cycle.sv | 138 +++++++++++++
 tb/tb_memory_access_cycle.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_cycle_pkg.sv
// Shared definitions for the MEM stage: data width, FSM encodings, WB bubble values
// and the control code that steers the MEM->WB register.
package memory_access_cycle_pkg;

    localparam int MEM_XLEN            = 32;
    localparam int MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam logic BUBBLE_REGWRITE = 1'b0;
    localparam logic BUBBLE_MISALIGN = 1'b0;

    typedef enum logic [1:0] {
        WB_LOAD     = 2'd0,
        WB_BUBBLE   = 2'd1,
        WB_MISALIGN = 2'd2
    } wb_ctl_e;

    function automatic logic is_misaligned(input logic access, input logic [1:0] lsb);
        return access && (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/memory_access_cycle_mem_wb_reg.sv
// MEM->WB pipeline register. Loads all fields, inserts a bubble, or records a
// misaligned access, as selected by ctl_i.
module mem_wb_reg
    import memory_access_cycle_pkg::*;
#(
    parameter int XLEN = MEM_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  wb_ctl_e         ctl_i,
    input  logic            load_data_i,
    input  logic            reg_write_i,
    input  logic            result_src_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] read_data_i,
    output logic            reg_write_o,
    output logic            result_src_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] read_data_o,
    output logic            misalign_o
);

    logic            reg_write_q;
    logic            result_src_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic [XLEN-1:0] alu_result_q;
    logic [XLEN-1:0] read_data_q;
    logic            misalign_q;

    // Bubble and misalign only touch the control bits; data fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            misalign_q   <= 1'b0;
        end else begin
            case (ctl_i)
                WB_BUBBLE: begin
                    reg_write_q <= BUBBLE_REGWRITE;
                    misalign_q  <= BUBBLE_MISALIGN;
                end
                WB_MISALIGN: begin
                    reg_write_q <= 1'b0;
                    misalign_q  <= 1'b1;
                end
                default: begin
                    reg_write_q  <= reg_write_i;
                    result_src_q <= result_src_i;
                    rd_q         <= rd_i;
                    pc_plus4_q   <= pc_plus4_i;
                    alu_result_q <= alu_result_i;
                    misalign_q   <= 1'b0;
                    if (load_data_i) begin
                        read_data_q <= read_data_i;
                    end
                end
            endcase
        end
    end

    assign reg_write_o  = reg_write_q;
    assign result_src_o = result_src_q;
    assign rd_o         = rd_q;
    assign pc_plus4_o   = pc_plus4_q;
    assign alu_result_o = alu_result_q;
    assign read_data_o  = read_data_q;
    assign misalign_o   = misalign_q;

endmodule

// File: rtl/memory_access_cycle.sv
// RV32I MEM stage: req/ack data bus with wait states, upstream stall and MEM->WB register.
// Optional bus-abort timeout and BusErrW port are enabled by defining MEM_TIMEOUT_EN.
module memory_access_cycle
    import memory_access_cycle_pkg::*;
#(
    parameter int XLEN = MEM_XLEN
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic            ResultSrcM,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] ALU_ResultM,
    output logic            StallM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            RegWriteW,
    output logic            ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic            MisalignW
`ifdef MEM_TIMEOUT_EN
    ,
    output logic            BusErrW
`endif
);

    logic       access;
    logic       misaligned;
    logic       req_raw;
    logic       timeout_hit;
    wb_ctl_e    wb_ctl;
    mem_state_e state_q;

    assign access     = MemWriteM | ResultSrcM;
    assign misaligned = is_misaligned(access, ALU_ResultM[1:0]);
    // Reset gates the bus so nothing leaks out while rst is held.
    assign req_raw    = access & ~misaligned & ~rst;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic          bus_err_q;

    assign timeout_hit = (state_q == MEM_WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign BusErrW     = bus_err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    assign dmem_req   = req_raw & ~timeout_hit;
    assign StallM     = dmem_req & ~dmem_ack;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALU_ResultM;
    assign dmem_wdata = WriteDataM;

    always_comb begin
        wb_ctl = WB_LOAD;
        if (StallM || timeout_hit) begin
            wb_ctl = WB_BUBBLE;
        end else if (misaligned) begin
            wb_ctl = WB_MISALIGN;
        end
    end

    // A dropped request in WAIT (abort or upstream release) also returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MEM_IDLE;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            bus_err_q <= timeout_hit;
`endif
            case (state_q)
                MEM_IDLE: begin
                    if (dmem_req && !dmem_ack) begin
                        state_q <= MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_req || dmem_ack) begin
                        state_q <= MEM_IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    mem_wb_reg #(
        .XLEN(XLEN)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .ctl_i        (wb_ctl),
        .load_data_i  (ResultSrcM),
        .reg_write_i  (RegWriteM),
        .result_src_i (ResultSrcM),
        .rd_i         (RD_M),
        .pc_plus4_i   (PCPlus4M),
        .alu_result_i (ALU_ResultM),
        .read_data_i  (dmem_rdata),
        .reg_write_o  (RegWriteW),
        .result_src_o (ResultSrcW),
        .rd_o         (RD_W),
        .pc_plus4_o   (PCPlus4W),
        .alu_result_o (ALU_ResultW),
        .read_data_o  (ReadDataW),
        .misalign_o   (MisalignW)
    );

endmodule

// File: tb/tb_memory_access_cycle.sv
// Scoreboard bench for memory_access_cycle: directed cases followed by random
// instruction traffic against a word-addressed memory model.
module tb_memory_access_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        StallM, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        RegWriteW, ResultSrcW, MisalignW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef MEM_TIMEOUT_EN
    logic        BusErrW;
`endif

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    memory_access_cycle #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .MisalignW(MisalignW),
        .BusErrW(BusErrW)
    );
`else
    memory_access_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .MisalignW(MisalignW)
    );
`endif

    typedef struct {
        logic        mis;
        logic        rsrc;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rdata;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    wb_t         wb_q[$];
    bus_t        bus_q[$];
    logic [31:0] mem[logic [31:0]];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // WB monitor: every architecturally visible WB result must match the next expectation.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!rst && (RegWriteW || MisalignW)) begin
                if (wb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got RegWriteW=%b MisalignW=%b want no output",
                             RegWriteW, MisalignW);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_misalign", 32'(MisalignW), 32'(e.mis));
                    chk("wb_regwrite", 32'(RegWriteW), 32'(!e.mis));
                    if (!e.mis) begin
                        chk("wb_rd", 32'(RD_W), 32'(e.rd));
                        chk("wb_pc4", PCPlus4W, e.pc4);
                        chk("wb_alu", ALU_ResultW, e.alu);
                        chk("wb_rsrc", 32'(ResultSrcW), 32'(e.rsrc));
                        if (e.rsrc) chk("wb_rdata", ReadDataW, e.rdata);
                    end
                end
            end
        end
    end

    // Bus monitor: every completed handshake must match the next expected access.
    initial begin
        bus_t b;
        forever begin
            @(negedge clk);
            if (dmem_req && dmem_ack) begin
                if (bus_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bus_unexpected: got addr=%h want no access", dmem_addr);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_we", 32'(dmem_we), 32'(b.we));
                    chk("bus_addr", dmem_addr, b.addr);
                    if (b.we) chk("bus_wdata", dmem_wdata, b.wdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got no end of test want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // One instruction through MEM; bus answers after lat wait cycles.
    task automatic issue(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] alu,
                         input int lat);
        logic        acc, mis, go;
        logic [31:0] rdv;
        int          stalls;
        acc = mw | rs;
        mis = acc && (alu[1:0] != 2'b00);
        go  = acc && !mis;
        rdv = mem.exists(alu) ? mem[alu] : ~alu;
        if (mis) wb_q.push_back('{1'b1, rs, rd, pc4, alu, 32'h0});
        else if (rw) wb_q.push_back('{1'b0, rs, rd, pc4, alu, rdv});
        if (go) bus_q.push_back('{mw, alu, wd});
        if (go && mw) mem[alu] = wd;

        @(posedge clk);
        #1;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
        PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = alu;
        dmem_ack   = go ? (lat == 0) : 1'($urandom_range(0, 1));
        dmem_rdata = (go && dmem_ack) ? rdv : $urandom;
        stalls = 0;
        @(negedge clk);
        chk("req_first", 32'(dmem_req), 32'(go));
        while (StallM) begin
            stalls++;
            if (stalls > 40) begin
                bad++;
                $display("FAIL stall_bound: got >40 stall cycles want %0d", lat);
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "stall bound");
            end
            @(posedge clk);
            #1;
            dmem_ack   = (stalls >= lat);
            dmem_rdata = dmem_ack ? rdv : $urandom;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(stalls), go ? 32'(lat) : 32'h0);
    endtask

    initial begin
        int          kind;
        logic [31:0] a;
        rst = 1'b1;
        RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = 0;
        PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0;
        dmem_ack = 0; dmem_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_regwrite", 32'(RegWriteW), 32'h0);
        chk("rst_misalign", 32'(MisalignW), 32'h0);
        chk("rst_readdata", ReadDataW, 32'h0);
        chk("rst_req", 32'(dmem_req), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        mem[32'h10] = 32'hDEADBEEF;
        issue(1, 0, 1, 5'd3, 32'h4, 32'h0, 32'h10, 0);
        issue(0, 1, 0, 5'd0, 32'h8, 32'h1234, 32'h20, 3);
        issue(1, 0, 0, 5'd5, 32'hC, 32'h0, 32'h7, 0);
        issue(1, 0, 1, 5'd6, 32'h10, 32'h0, 32'h13, 0);

        @(posedge clk);
        #1;
        RegWriteM = 1; MemWriteM = 0; ResultSrcM = 1; RD_M = 5'd9; ALU_ResultM = 32'h40;
        dmem_ack = 0;
        @(negedge clk);
        chk("rstw_stall1", 32'(StallM), 32'h1);
        @(negedge clk);
        chk("rstw_stall2", 32'(StallM), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_req", 32'(dmem_req), 32'h0);
        chk("rstw_stall", 32'(StallM), 32'h0);
        chk("rstw_regwrite", 32'(RegWriteW), 32'h0);
        chk("rstw_rd", 32'(RD_W), 32'h0);
        RegWriteM = 0; ResultSrcM = 0; RD_M = 0; ALU_ResultM = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_alu", ALU_ResultW, 32'h0);
        chk("post_rst_pc4", PCPlus4W, 32'h0);
        issue(1, 0, 1, 5'd10, 32'h44, 32'h0, 32'h10, 1);

`ifdef MEM_TIMEOUT_EN
        begin
            int st;
            @(posedge clk);
            #1;
            RegWriteM = 1; MemWriteM = 0; ResultSrcM = 1; RD_M = 5'd11; ALU_ResultM = 32'h50;
            dmem_ack = 0;
            st = 0;
            @(negedge clk);
            while (StallM && st < 40) begin
                st++;
                @(negedge clk);
            end
            chk("to_stalls", 32'(st), 32'h4);
            chk("to_req", 32'(dmem_req), 32'h0);
            @(posedge clk);
            #1;
            RegWriteM = 0; ResultSrcM = 0; ALU_ResultM = 0;
            @(negedge clk);
            chk("to_buserr", 32'(BusErrW), 32'h1);
            chk("to_regwrite", 32'(RegWriteW), 32'h0);
            @(negedge clk);
            chk("to_buserr_clr", 32'(BusErrW), 32'h0);
        end
`endif

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 4);
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            case (kind)
                0: issue(1'($urandom_range(0, 1)), 0, 0, 5'($urandom), $urandom, $urandom,
                         $urandom, 0);
                1: issue(1, 0, 1, 5'($urandom), $urandom, $urandom, a, $urandom_range(0, 3));
                2: issue(0, 1, 0, 5'($urandom), $urandom, $urandom, a, $urandom_range(0, 3));
                3: issue(1, 1'($urandom_range(0, 1)), 1, 5'($urandom), $urandom, $urandom,
                         a + 32'($urandom_range(1, 3)), 0);
                default: issue(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
            endcase
        end

        issue(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
        issue(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'h0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);
        finish_run();
    end

endmodule
